// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and segment table for the 4-digit scan driver
package seg7_pkg;

    localparam int SCAN_DIV_DEFAULT  = 50000;
    localparam int BLINK_DIV_DEFAULT = 250;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Active-low g..a patterns, entry 15 first so SEG7_TABLE[v] is glyph v.
    localparam logic [15:0][6:0] SEG7_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex digit to active-low g..a segment decode
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);

    assign seg_n = SEG7_TABLE[hex];

endmodule

// File: rtl/seg7_scan_blink.sv
// rtl/seg7_scan_blink.sv - frame-coherent 4-digit multiplexed 7-segment driver with blank and blink
module seg7_scan_blink
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = SCAN_DIV_DEFAULT,
    parameter int BLINK_DIV = BLINK_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [15:0] HEXS,
    input  logic [3:0]  points,
    input  logic [3:0]  LES,
    input  logic [3:0]  blink,
    output logic [7:0]  SEG,
    output logic [3:0]  AN
);

    localparam int PRE_W   = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PRE_W-1:0]   pre_cnt_q,   pre_cnt_d;
    logic [1:0]         idx_q,       idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q,     phase_d;
    logic               load_pend_q, load_pend_d;
    logic [15:0]        sh_hexs_q,   sh_hexs_d;
    logic [3:0]         sh_points_q, sh_points_d;
    logic [3:0]         sh_les_q,    sh_les_d;
    logic [3:0]         sh_blink_q,  sh_blink_d;
    logic [7:0]         seg_q,       seg_d;
    logic [3:0]         an_q,        an_d;

    logic               tick;
    logic               load;
    logic               dark;
    logic [3:0]         cur_hex;
    logic [6:0]         cur_glyph;

    assign cur_hex = sh_hexs_q[{idx_q, 2'b00} +: 4];

    hex_to_seg7 u_decode (
        .hex   (cur_hex),
        .seg_n (cur_glyph)
    );

    always_comb begin
        pre_cnt_d   = pre_cnt_q;
        idx_d       = idx_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        load_pend_d = load_pend_q;
        sh_hexs_d   = sh_hexs_q;
        sh_points_d = sh_points_q;
        sh_les_d    = sh_les_q;
        sh_blink_d  = sh_blink_q;

        tick = (pre_cnt_q == PRE_W'(SCAN_DIV - 1));

        if (tick) begin
            pre_cnt_d = '0;
            idx_d     = idx_q + 2'd1;
            if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end else begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
        end

        // Capture only at the frame boundary so a digit never tears mid-frame;
        // the pending flag lets the very first post-reset frame pick up live input.
        load = (tick && (idx_q == 2'd3)) || load_pend_q;
        if (load) begin
            sh_hexs_d   = HEXS;
            sh_points_d = points;
            sh_les_d    = LES;
            sh_blink_d  = blink;
            load_pend_d = 1'b0;
        end

        // A dark digit keeps its anode on so every slot has the same duty.
        dark  = sh_les_q[idx_q] | (sh_blink_q[idx_q] & phase_q);
        an_d  = ~(4'b0001 << idx_q);
        seg_d = dark ? SEG_OFF : {~sh_points_q[idx_q], cur_glyph};
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            pre_cnt_q   <= '0;
            idx_q       <= 2'd0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            load_pend_q <= 1'b1;
            sh_hexs_q   <= '0;
            sh_points_q <= '0;
            sh_les_q    <= '0;
            sh_blink_q  <= '0;
            seg_q       <= SEG_OFF;
            an_q        <= AN_OFF;
        end else begin
            pre_cnt_q   <= pre_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            load_pend_q <= load_pend_d;
            sh_hexs_q   <= sh_hexs_d;
            sh_points_q <= sh_points_d;
            sh_les_q    <= sh_les_d;
            sh_blink_q  <= sh_blink_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign SEG = seg_q;
    assign AN  = an_q;

endmodule
